// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: width defaults and
// the fetch FSM state encoding.
package fetch_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_REQ   = 3'd2,
      ST_DROP  = 3'd3,
      ST_FULL  = 3'd4
   } state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: captures the PC, reads one word from instruction
// memory, holds it for the decoder and asks the PC to advance.
//
// Handshakes:
//   memory  - mem_req/mem_addr are held stable until mem_ack; a request is
//             never withdrawn except by reset. mem_ack may arrive in the
//             same cycle as mem_req.
//   decoder - ir_valid/ir_ready: a transfer happens in any cycle where both
//             are 1; ir_data/ir_pc are held unchanged while ir_valid=1.
//   pc      - pc_ld flushes the stage; pc_adv pulses once per accepted word
//             and never together with pc_ld.
// fsm_state exposes the FSM register for observation.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_addr,
   input  logic          pc_ld,
   output logic          pc_adv,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          ir_valid,
   output logic [DW-1:0] ir_data,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_ready,
   output logic [2:0]    fsm_state
);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] ir_data_q;
   logic [AW-1:0] ir_pc_q;
   logic          capture;

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A load in REQ without an ack parks in DROP so the
   // outstanding read completes before the new address is latched.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_LATCH;
         ST_LATCH: if (!pc_ld) state_nxt = ST_REQ;
         ST_REQ: begin
            if (mem_ack) begin
               state_nxt = pc_ld ? ST_LATCH : ST_FULL;
            end else if (pc_ld) begin
               state_nxt = ST_DROP;
            end
         end
         ST_DROP:  if (mem_ack) state_nxt = ST_LATCH;
         ST_FULL:  if (ir_ready || pc_ld) state_nxt = ST_LATCH;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output decode; everything is forced to zero while rst is high so an
   // in-flight request is abandoned and a late ack has nothing to act on.
   always_comb begin
      mem_req  = 1'b0;
      pc_adv   = 1'b0;
      ir_valid = 1'b0;
      capture  = 1'b0;
      if (!rst) begin
         case (state)
            ST_REQ: begin
               mem_req = 1'b1;
               if (mem_ack && !pc_ld) begin
                  pc_adv  = 1'b1;
                  capture = 1'b1;
               end
            end
            ST_DROP: mem_req  = 1'b1;
            ST_FULL: ir_valid = 1'b1;
            default: ;
         endcase
      end
      mem_addr = rst ? '0 : fetch_addr;
      ir_data  = rst ? '0 : ir_data_q;
      ir_pc    = rst ? '0 : ir_pc_q;
   end

   // Address latch and instruction register; the PC value is used verbatim.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr <= '0;
         ir_data_q  <= '0;
         ir_pc_q    <= '0;
      end else begin
         if (state == ST_LATCH) begin
            fetch_addr <= pc_addr;
         end
         if (capture) begin
            ir_data_q <= mem_rdata;
            ir_pc_q   <= fetch_addr;
         end
      end
   end

   assign fsm_state = state;

endmodule
